// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: round-robin with a port-1 burst lock.
// Build option DMEM_ARB_FIXED_PRIO_EN: port 0 always wins contention and the lock logic is not built.

module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              wait0,
    output logic              wait1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_we;

    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_wdata_hold;
    logic              r_pend_vld;
    logic              r_pend_port;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic w_unused_lock;
    assign w_unused_lock = lock1;

    // Port 0 wins every contended cycle; nothing is grant-history dependent.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset) begin
            w_gnt0 = req0;
            w_gnt1 = req1 && !req0;
        end
    end
`else
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    logic             r_last1;
    logic             r_prev1;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             w_lock_hold;

    // Lock only engages once port 1 actually held the grant in the previous cycle.
    assign w_lock_hold = r_prev1 && lock1 && (r_burst_cnt < BURST_MAX);

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset) begin
            if (req0 && req1) begin
                if (w_lock_hold) begin
                    w_gnt1 = 1'b1;
                end else if (r_last1) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last1     <= 1'b1;
            r_prev1     <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_prev1 <= w_gnt1;
            if (w_any) begin
                r_last1 <= w_gnt1;
            end
            if (w_gnt0 || !lock1) begin
                r_burst_cnt <= '0;
            end else if (w_gnt1 && (r_burst_cnt < BURST_MAX)) begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end
        end
    end
`endif

    assign w_any       = w_gnt0 || w_gnt1;
    assign w_sel_addr  = w_gnt1 ? addr1  : addr0;
    assign w_sel_wdata = w_gnt1 ? wdata1 : wdata0;
    assign w_sel_we    = w_gnt1 ? we1    : we0;

    assign wait0     = !w_gnt0;
    assign wait1     = !w_gnt1;
    assign mem_wren  = w_any && w_sel_we;
    assign mem_addr  = w_any ? w_sel_addr  : r_addr_hold;
    assign mem_wdata = w_any ? w_sel_wdata : r_wdata_hold;

    // Read return: one pending slot, data passes straight through from memory.
    assign rvalid0 = r_pend_vld && !r_pend_port;
    assign rvalid1 = r_pend_vld &&  r_pend_port;
    assign rdata0  = rvalid0 ? mem_rdata : r_rdata0;
    assign rdata1  = rvalid1 ? mem_rdata : r_rdata1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
            r_pend_vld   <= 1'b0;
            r_pend_port  <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            if (w_any) begin
                r_addr_hold  <= w_sel_addr;
                r_wdata_hold <= w_sel_wdata;
            end
            r_pend_vld  <= w_any && !w_sel_we;
            r_pend_port <= w_gnt1;
            if (rvalid0) begin
                r_rdata0 <= mem_rdata;
            end
            if (rvalid1) begin
                r_rdata1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed corner sequences, and random traffic vs a reference model.
// Honours DMEM_ARB_FIXED_PRIO_EN the same way the design does.

module tb_dmem_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clock;
    logic          reset;
    logic          req0, req1, we0, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          wait0, wait1, rvalid0, rvalid1, mem_wren;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int n_pass;
    int n_total;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock1(lock1), .wait0(wait0), .wait1(wait1),
        .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port RAM; unwritten words read back a recognisable pattern.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {20'hC0FFE, a};
    endfunction

    logic [DW-1:0] ram    [0:DEPTH-1];
    bit            ram_wr [0:DEPTH-1];

    always @(posedge clock) begin
        if (mem_wren) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end

    // Reference model: grant history, burst count, one queued read result, memory image.
    int            m_last, m_prev, m_cnt, m_pend, cur_g;
    logic [DW-1:0] m_pdata, m_rd0, m_rd1;
    logic [AW-1:0] m_hold;
    logic [DW-1:0] m_mem [0:DEPTH-1];

    task automatic model_reset();
        m_last = 1; m_prev = -1; m_cnt = 0; m_pend = -1;
        m_pdata = '0; m_rd0 = '0; m_rd1 = '0; m_hold = '0;
    endtask

    function automatic int m_grant(input logic r0, input logic r1, input logic lk);
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        if (lk || !lk) return 0;
        return 0;
`else
        if (m_prev == 1 && lk && m_cnt < int'(MB)) return 1;
        return (m_last == 1) ? 0 : 1;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wait0"},   64'(wait0),    64'(1));
        chk({tag, "_wait1"},   64'(wait1),    64'(1));
        chk({tag, "_wren"},    64'(mem_wren), 64'(0));
        chk({tag, "_addr"},    64'(mem_addr), 64'(0));
        chk({tag, "_rvalid0"}, 64'(rvalid0),  64'(0));
        chk({tag, "_rvalid1"}, 64'(rvalid1),  64'(0));
        chk({tag, "_rdata0"},  64'(rdata0),   64'(0));
        chk({tag, "_rdata1"},  64'(rdata1),   64'(0));
    endtask

    // Drive one cycle's inputs at the falling edge and compare everything against the model.
    task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1,
                         input logic lk, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic [AW-1:0] ea;
        @(negedge clock);
        req0 = r0; req1 = r1; we0 = w0; we1 = w1; lock1 = lk;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        #1;
        cur_g = m_grant(r0, r1, lk);
        ea = (cur_g == 0) ? a0 : (cur_g == 1) ? a1 : m_hold;
        chk("wait0",    64'(wait0),    64'(cur_g != 0));
        chk("wait1",    64'(wait1),    64'(cur_g != 1));
        chk("mem_wren", 64'(mem_wren), 64'((cur_g == 0 && w0) || (cur_g == 1 && w1)));
        chk("mem_addr", 64'(mem_addr), 64'(ea));
        if (cur_g >= 0) chk("mem_wdata", 64'(mem_wdata), 64'((cur_g == 0) ? d0 : d1));
        chk("rvalid0",  64'(rvalid0),  64'(m_pend == 0));
        chk("rvalid1",  64'(rvalid1),  64'(m_pend == 1));
        chk("rdata0",   64'(rdata0),   64'((m_pend == 0) ? m_pdata : m_rd0));
        chk("rdata1",   64'(rdata1),   64'((m_pend == 1) ? m_pdata : m_rd1));
    endtask

    task automatic commit();
        logic [AW-1:0] a;
        @(posedge clock);
        if (m_pend == 0) m_rd0 = m_pdata;
        else if (m_pend == 1) m_rd1 = m_pdata;
        m_pend = -1;
        if (cur_g >= 0) begin
            a = (cur_g == 1) ? addr1 : addr0;
            m_hold = a;
            if ((cur_g == 1) ? we1 : we0) begin
                m_mem[a] = (cur_g == 1) ? wdata1 : wdata0;
            end else begin
                m_pend  = cur_g;
                m_pdata = m_mem[a];
            end
            m_last = cur_g;
        end
        if (cur_g == 0 || !lock1) m_cnt = 0;
        else if (cur_g == 1 && m_cnt < int'(MB)) m_cnt++;
        m_prev = cur_g;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        commit();
    endtask

    // Hold reset with both ports requesting so gating of the grant is visible.
    task automatic apply_reset();
        @(negedge clock);
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1; lock1 = 1'b1;
        addr0 = 12'h0AA; addr1 = 12'h0BB;
        reset = 1'b0;
        model_reset();
        #1 check_reset_vals("rst_a");
        @(negedge clock);
        #1 check_reset_vals("rst_b");
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
        reset = 1'b1;
    endtask

    typedef struct {
        logic          r0, r1, lk;
        logic [AW-1:0] a0, a1;
        logic          e_wait0, e_wait1, e_wren;
        logic [AW-1:0] e_addr;
    } vec_t;

    function automatic vec_t mkv(input logic r0, input logic r1, input logic lk,
                                 input int i, input int g, input logic [AW-1:0] hold);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.lk = lk;
        v.a0 = AW'(32'h100 + i);
        v.a1 = AW'(32'h200 + i);
        v.e_wait0 = (g != 0);
        v.e_wait1 = (g != 1);
        v.e_wren  = (g >= 0);
        v.e_addr  = (g == 0) ? v.a0 : (g == 1) ? v.a1 : hold;
        return v;
    endfunction

    initial begin
        vec_t          tbl[$];
        logic          r0, r1, lk;
        n_pass = 0; n_total = 0;
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = init_val(AW'(i));
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        cur_g = -1;
        model_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        apply_reset();

`ifdef DMEM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) tbl.push_back(mkv(1, 1, 1, i, 0, '0));
        tbl.push_back(mkv(0, 1, 1, 5, 1, '0));
        tbl.push_back(mkv(1, 1, 1, 6, 0, '0));
        tbl.push_back(mkv(0, 0, 1, 7, -1, 12'h106));
`else
        begin
            int gseq[12] = '{0, 1, 0, 1, 0, 1, 1, 1, 1, 0, 1, 1};
            for (int i = 0; i < 12; i++) tbl.push_back(mkv(1, 1, i >= 5, i, gseq[i], '0));
        end
        tbl.push_back(mkv(1, 0, 1, 12, 0, '0));
        tbl.push_back(mkv(0, 0, 1, 13, -1, 12'h10C));
`endif
        foreach (tbl[i]) begin
            drive(tbl[i].r0, tbl[i].r1, 1'b1, 1'b1, tbl[i].lk, tbl[i].a0, tbl[i].a1,
                  DW'(32'h1000 + i), DW'(32'h2000 + i));
            chk($sformatf("tbl%0d_wait0", i), 64'(wait0),    64'(tbl[i].e_wait0));
            chk($sformatf("tbl%0d_wait1", i), 64'(wait1),    64'(tbl[i].e_wait1));
            chk($sformatf("tbl%0d_wren", i),  64'(mem_wren), 64'(tbl[i].e_wren));
            chk($sformatf("tbl%0d_addr", i),  64'(mem_addr), 64'(tbl[i].e_addr));
            commit();
        end

        // Single requester: write then read back the same word.
        drive(1, 0, 1, 0, 0, 12'h005, 12'h000, 32'hDEADBEEF, '0);
        chk("wr_wait0", 64'(wait0), 64'(0));
        chk("wr_wren",  64'(mem_wren), 64'(1));
        chk("wr_addr",  64'(mem_addr), 64'(12'h005));
        commit();
        drive(1, 0, 0, 0, 0, 12'h005, 12'h000, '0, '0);
        chk("rd_wait0", 64'(wait0), 64'(0));
        chk("rd_wren",  64'(mem_wren), 64'(0));
        commit();
        drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
        chk("rd_rvalid0", 64'(rvalid0), 64'(1));
        chk("rd_rdata0",  64'(rdata0),  64'(32'hDEADBEEF));
        chk("rd_rvalid1", 64'(rvalid1), 64'(0));
        commit();
        drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
        chk("rd_hold_rvalid0", 64'(rvalid0), 64'(0));
        chk("rd_hold_rdata0",  64'(rdata0),  64'(32'hDEADBEEF));
        commit();

        // Interleaved reads from both ports on consecutive cycles.
        drive(1, 0, 0, 0, 0, 12'h010, 12'h000, '0, '0);
        commit();
        drive(0, 1, 0, 0, 0, 12'h000, 12'h020, '0, '0);
        chk("il_rvalid0", 64'(rvalid0), 64'(1));
        chk("il_rdata0",  64'(rdata0),  64'(32'hC0FFE010));
        chk("il_rvalid1", 64'(rvalid1), 64'(0));
        commit();
        drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
        chk("il_rvalid1b", 64'(rvalid1), 64'(1));
        chk("il_rdata1b",  64'(rdata1),  64'(32'hC0FFE020));
        chk("il_rvalid0b", 64'(rvalid0), 64'(0));
        commit();

        // Reset lands between a read accept and its return: the result must vanish.
        drive(1, 0, 0, 0, 0, 12'h030, 12'h000, '0, '0);
        commit();
        #2;
        reset = 1'b0;
        req0 = 1'b0;
        model_reset();
        #1 check_reset_vals("mid_a");
        @(negedge clock);
        #1 check_reset_vals("mid_b");
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
            chk($sformatf("mid_norv0_%0d", k), 64'(rvalid0), 64'(0));
            chk($sformatf("mid_norv1_%0d", k), 64'(rvalid1), 64'(0));
            commit();
        end

        // Random traffic; a request stays up until the model says it was accepted.
        for (int n = 0; n < 600; n++) begin
            r0 = (req0 && cur_g != 0) || ($urandom_range(0, 9) < 6);
            r1 = (req1 && cur_g != 1) || ($urandom_range(0, 9) < 6);
            lk = ($urandom_range(0, 3) != 0);
            drive(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lk,
                  AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                  DW'($urandom), DW'($urandom));
            commit();
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the processor's single-port data memory. Port 0 is the processor's load/store path; port 1 is a loader/debug port that fills or inspects data memory while the processor runs. Each cycle the block grants at most one requester, drives the memory's address, write-data and write-enable, and routes the 1-cycle-latency synchronous read data back to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 12, word-address width of data memory
- DATA_W, 32, data width
- MAX_BURST, 8, maximum consecutive port-1 accesses under lock before a forced yield (1..255)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- req0, req1  input  1  access request; held until accepted
- we0, we1  input  1  1 = write, 0 = read
- addr0, addr1  input  ADDR_W  word address
- wdata0, wdata1  input  DATA_W  write data
- lock1  input  1  port 1 requests burst ownership
- wait0, wait1  output  1  1 = request not accepted this cycle
- rdata0, rdata1  output  DATA_W  read data, valid when matching rvalid is 1
- rvalid0, rvalid1  output  1  one-cycle pulse, read data returned
- mem_addr  output  ADDR_W  to memory
- mem_wdata  output  DATA_W  to memory
- mem_wren  output  1  to memory
- mem_rdata  input  DATA_W  from memory, one cycle after address

## Operation
- Access accepted for port N in a cycle when reqN=1 and waitN=0; exactly one port is accepted per cycle.
- Grant is combinational from req0, req1, the last-grant register, and the burst state.
- Round-robin: if both request, grant the port not granted last. A single requester is always granted.
- Burst lock: if port 1 was granted last cycle and lock1=1, port 1 keeps the grant over port 0 while burst_cnt < MAX_BURST.
  - burst_cnt increments on each locked port-1 accept and clears on any port-0 accept or when lock1=0.
  - At burst_cnt == MAX_BURST with req0=1, port 0 is granted for one cycle, then the lock may resume.
- Mux:
  - Memory outputs mem_addr/mem_wdata follow the granted port.
  - mem_wren = granted & we.
  - With no grant: mem_wren=0, mem_addr holds its last value.
- Read return: a read accept sets a one-entry pending register {valid, port}. The next cycle pulses rvalidN for that port, with rdataN = mem_rdata. rdata of the non-returning port holds its last value.
- Writes produce no rvalid.
- Back-to-back reads return every cycle, in accept order.

## Timing
- Grant/wait/mem_* are combinational, in the same cycle as req.
- Read latency: accept in cycle T -> rvalid in cycle T+1.
- Reset (reset=0, asynchronous):
  - rvalid0=rvalid1=0, rdata0=rdata1=0.
  - wait0=wait1=1, mem_wren=0, mem_addr=0.
  - last-grant=port 1, so port 0 wins the first contended cycle; burst_cnt=0.
- Reset asserted with a read pending: the pending read is discarded and no rvalid is produced after release.
- First accept is possible in the first rising edge after reset deasserts.
- Simultaneous req0/req1 with lock1=1 but port 1 not granted last cycle: round-robin decides; the lock takes effect only after port 1 wins.
- we and addr change while waitN=1 is legal; the value sampled is the one in the accept cycle.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN defined: port 0 (processor) always wins contention. lock1 and burst_cnt are ignored (lock logic not built), and port 1 is served only when req0=0.
- Undefined: round-robin with burst lock as above.

## Test plan
- Reset mid-read: read accepted at T, reset pulled low before T+1 edge -> no rvalid0/rvalid1 after release; all outputs at reset values during reset.
- Single requester: port 0 writes 0xDEADBEEF to addr 0x005 then reads addr 0x005 -> wait0=0 both cycles, mem_wren=1 then 0, rvalid0 pulse with rdata0=0xDEADBEEF one cycle after the read.
- Contention: req0=req1=1 held 6 cycles after reset -> accepts alternate 0,1,0,1,0,1; wait is asserted on the loser each cycle.
- Burst lock, MAX_BURST=4: port 1 wins, lock1=1, req0=1 throughout -> port 1 accepted 4 consecutive cycles, port 0 accepted next cycle, port 1 resumes.
- Interleaved reads: port 0 reads 0x010, port 1 reads 0x020 in consecutive cycles -> rvalid0 then rvalid1 on consecutive cycles with correct data each, never both together.
- With DMEM_ARB_FIXED_PRIO_EN: req0=req1=1 for 5 cycles -> port 0 accepted all 5 and wait1=1 throughout; port 1 accepted in the first cycle req0=0.
